// File: rtl/gb_swap_sched.sv
// Global-buffer bank role sequencer: counts fill beats, collects read-done pulses, rotates bank mapping.
// Optional GB_SCHED_PERF_EN adds stall_cycles, a saturating count of cycles spent waiting on readers.
module gb_swap_sched #(
   parameter int NUM_RBANK = 2,
   parameter int NUM_WBANK = 1,
   parameter int DEPTH     = 128
) (
   input  logic                                           clock,
   input  logic                                           reset_n,
   input  logic                                           start,
   input  logic [15:0]                                    num_batches,
   input  logic                                           wr_beat,
   output logic                                           wr_ready,
   input  logic [NUM_RBANK-1:0]                           rd_done,
   output logic [NUM_RBANK*$clog2(NUM_RBANK+NUM_WBANK)-1:0] rsel,
   output logic [NUM_WBANK*$clog2(NUM_RBANK+NUM_WBANK)-1:0] wsel,
   output logic                                           swap,
   output logic                                           busy,
   output logic                                           done,
   output logic [2:0]                                     state_dbg
`ifdef GB_SCHED_PERF_EN
   ,
   output logic [31:0]                                    stall_cycles
`endif
);

   localparam int NB     = NUM_RBANK + NUM_WBANK;
   localparam int SEL_W  = $clog2(NB);
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam int LOAD_W = $clog2(NUM_RBANK + 1);

   // Handshake: wr_beat counts only in a cycle where wr_ready is high; there is no back-pressure
   // on rd_done, a pulse is either latched into its port flag or dropped.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_WAIT_RD = 3'd2,
      S_SWAP    = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t                 state, state_nxt;
   logic [SEL_W-1:0]       base;
   logic [FILL_W-1:0]      fill_cnt;
   logic [15:0]            batch_cnt;
   logic [15:0]            nb_q;
   logic [LOAD_W-1:0]      loaded;
   logic [NUM_RBANK-1:0]   rd_flags;
   logic [NUM_RBANK-1:0]   valid_mask;
   logic [NUM_RBANK-1:0]   rd_hit;
   logic                   all_rd;
   logic                   start_ok;
   logic                   done_q;

   // Index sums never exceed 2*NB-2, so a single conditional subtract is a full modulo.
   function automatic logic [SEL_W-1:0] wrap_nb(input int v);
      int r;
      r = (v >= NB) ? v - NB : v;
      return SEL_W'(r);
   endfunction

   function automatic logic [LOAD_W-1:0] next_loaded(input logic [LOAD_W-1:0] l);
      int s;
      s = int'(l) + NUM_WBANK;
      if (s > NUM_RBANK) s = NUM_RBANK;
      return LOAD_W'(s);
   endfunction

   always_comb begin
      valid_mask = '0;
      for (int i = 0; i < NUM_RBANK; i++)
         if (i >= NUM_RBANK - int'(loaded)) valid_mask[i] = 1'b1;
   end

   // A rd_done arriving this cycle counts toward completion immediately.
   assign rd_hit = rd_done & valid_mask;
   assign all_rd = &(rd_flags | rd_hit | ~valid_mask);

   always_comb begin
      wsel = '0;
      rsel = '0;
      for (int j = 0; j < NUM_WBANK; j++)
         wsel[j*SEL_W +: SEL_W] = wrap_nb(int'(base) + j);
      for (int i = 0; i < NUM_RBANK; i++)
         rsel[i*SEL_W +: SEL_W] = wrap_nb(int'(base) + NUM_WBANK + i);
   end

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      swap      = 1'b0;
      start_ok  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               if (num_batches != 16'd0) state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            wr_ready = 1'b1;
            if (wr_beat && fill_cnt == FILL_W'(DEPTH - 1)) state_nxt = S_WAIT_RD;
         end
         S_WAIT_RD: if (all_rd) state_nxt = S_SWAP;
         S_SWAP: begin
            swap      = 1'b1;
            state_nxt = (batch_cnt + 16'd1 == nb_q) ? S_DRAIN : S_FILL;
         end
         S_DRAIN: if (all_rd) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base      <= '0;
         fill_cnt  <= '0;
         batch_cnt <= '0;
         nb_q      <= '0;
         loaded    <= '0;
         rd_flags  <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (start_ok && num_batches == 16'd0) || (state == S_DRAIN && all_rd);
         case (state)
            S_IDLE: begin
               if (start_ok && num_batches != 16'd0) begin
                  nb_q      <= num_batches;
                  base      <= '0;
                  fill_cnt  <= '0;
                  batch_cnt <= '0;
                  loaded    <= '0;
                  rd_flags  <= '0;
               end
            end
            S_FILL: begin
               rd_flags <= rd_flags | rd_hit;
               if (wr_beat) fill_cnt <= fill_cnt + FILL_W'(1);
            end
            S_WAIT_RD, S_DRAIN: rd_flags <= rd_flags | rd_hit;
            S_SWAP: begin
               base      <= wrap_nb(int'(base) + NUM_WBANK);
               loaded    <= next_loaded(loaded);
               batch_cnt <= batch_cnt + 16'd1;
               fill_cnt  <= '0;
               rd_flags  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = done_q;
   assign state_dbg = state;

`ifdef GB_SCHED_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_cycles <= '0;
      else if (start_ok)
         stall_cycles <= '0;
      else if ((state == S_WAIT_RD || state == S_DRAIN) && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_gb_swap_sched.sv
// Bench for gb_swap_sched: directed scenarios plus random traffic, checked every cycle against a
// queue-of-banks reference model. Build with GB_SCHED_PERF_EN to also check stall_cycles.
module tb_gb_swap_sched;

   localparam int NR    = 2;
   localparam int NW    = 1;
   localparam int DEPTH = 4;
   localparam int NB    = NR + NW;
   localparam int SEL_W = 2;

   localparam int M_IDLE = 0, M_FILL = 1, M_WAIT = 2, M_SWAP = 3, M_DRAIN = 4;

   logic                  clock = 1'b0;
   logic                  reset_n;
   logic                  start;
   logic [15:0]           num_batches;
   logic                  wr_beat;
   logic                  wr_ready;
   logic [NR-1:0]         rd_done;
   logic [NR*SEL_W-1:0]   rsel;
   logic [NW*SEL_W-1:0]   wsel;
   logic                  swap;
   logic                  busy;
   logic                  done;
   logic [2:0]            state_dbg;
`ifdef GB_SCHED_PERF_EN
   logic [31:0]           stall_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int swap_seen = 0;
   int done_seen = 0;

   logic [SEL_W-1:0] exp_q[$];

   // reference model: bank roles kept as an ordered list (write banks first, then read ports)
   int m_order[NB];
   int m_phase, m_loaded, m_fill, m_batch, m_nb;
   bit m_flag[NR];
   bit m_done;
   int m_stall;

   gb_swap_sched #(.NUM_RBANK(NR), .NUM_WBANK(NW), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .num_batches (num_batches),
      .wr_beat     (wr_beat),
      .wr_ready    (wr_ready),
      .rd_done     (rd_done),
      .rsel        (rsel),
      .wsel        (wsel),
      .swap        (swap),
      .busy        (busy),
      .done        (done),
      .state_dbg   (state_dbg)
`ifdef GB_SCHED_PERF_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int k = 0; k < NB; k++) m_order[k] = k;
      for (int i = 0; i < NR; i++) m_flag[i] = 1'b0;
      m_phase = M_IDLE; m_loaded = 0; m_fill = 0; m_batch = 0; m_nb = 0;
      m_done = 1'b0; m_stall = 0;
   endfunction

   function automatic void m_step(input bit st, input int nb, input bit beat, input logic [NR-1:0] rdd);
      bit nd = 1'b0;
      bit all = 1'b1;
      bit hit[NR];
      int tmp;
      for (int i = 0; i < NR; i++) begin
         hit[i] = rdd[i] && (i >= NR - m_loaded);
         if ((i >= NR - m_loaded) && !(m_flag[i] || hit[i])) all = 1'b0;
      end
      if (m_phase == M_WAIT || m_phase == M_DRAIN) m_stall++;
      if (m_phase == M_FILL || m_phase == M_WAIT || m_phase == M_DRAIN)
         for (int i = 0; i < NR; i++) m_flag[i] = m_flag[i] | hit[i];
      case (m_phase)
         M_IDLE: if (st) begin
            m_stall = 0;
            if (nb == 0) nd = 1'b1;
            else begin
               for (int k = 0; k < NB; k++) m_order[k] = k;
               for (int i = 0; i < NR; i++) m_flag[i] = 1'b0;
               m_loaded = 0; m_fill = 0; m_batch = 0; m_nb = nb; m_phase = M_FILL;
            end
         end
         M_FILL: if (beat) begin
            m_fill++;
            if (m_fill == DEPTH) m_phase = M_WAIT;
         end
         M_WAIT: if (all) m_phase = M_SWAP;
         M_SWAP: begin
            for (int r = 0; r < NW; r++) begin
               tmp = m_order[0];
               for (int k = 0; k < NB - 1; k++) m_order[k] = m_order[k+1];
               m_order[NB-1] = tmp;
            end
            m_loaded = (m_loaded + NW > NR) ? NR : m_loaded + NW;
            m_batch++;
            m_fill = 0;
            for (int i = 0; i < NR; i++) m_flag[i] = 1'b0;
            m_phase = (m_batch == m_nb) ? M_DRAIN : M_FILL;
         end
         M_DRAIN: if (all) begin nd = 1'b1; m_phase = M_IDLE; end
         default: ;
      endcase
      m_done = nd;
   endfunction

   task automatic check_outputs();
      logic [NW*SEL_W-1:0] ew;
      logic [NR*SEL_W-1:0] er;
      for (int j = 0; j < NW; j++) ew[j*SEL_W +: SEL_W] = SEL_W'(m_order[j]);
      for (int i = 0; i < NR; i++) er[i*SEL_W +: SEL_W] = SEL_W'(m_order[NW+i]);
      chk("wsel", 32'(wsel), 32'(ew));
      chk("rsel", 32'(rsel), 32'(er));
      chk("busy", 32'(busy), 32'(m_phase != M_IDLE));
      chk("wr_ready", 32'(wr_ready), 32'(m_phase == M_FILL));
      chk("swap", 32'(swap), 32'(m_phase == M_SWAP));
      chk("done", 32'(done), 32'(m_done));
`ifdef GB_SCHED_PERF_EN
      chk("stall_cycles", stall_cycles, 32'(m_stall));
`endif
      if (swap) swap_seen++;
      if (done) done_seen++;
   endtask

   // driver: called at a negedge, checks current outputs then applies one cycle of inputs
   task automatic step(input bit st, input int nb, input bit beat, input logic [NR-1:0] rdd);
      start = st; num_batches = 16'(nb); wr_beat = beat; rd_done = rdd;
      check_outputs();
      m_step(st, nb, beat, rdd);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, '0);
   endtask

   task automatic beats(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 1'b1, '0);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0; start = 1'b0; wr_beat = 1'b0; rd_done = '0; num_batches = '0;
      #1;
      m_reset();
      check_outputs();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int s0, d0;
      reset_n = 1'b0; start = 1'b0; wr_beat = 1'b0; rd_done = '0; num_batches = '0;
      m_reset();
      @(negedge clock);
      // 1: reset values
      chk("rst_wsel", 32'(wsel), 32'd0);
      chk("rst_rsel", 32'(rsel), 32'b1001);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;

      // 2: single batch, loaded=0 so swap follows immediately
      step(1'b1, 1, 1'b0, '0);
      chk("t2_wr_ready", 32'(wr_ready), 32'd1);
      beats(DEPTH);
      chk("t2_wait_noswap", 32'(swap), 32'd0);
      idle(1);
      chk("t2_swap", 32'(swap), 32'd1);
      idle(1);
      chk("t2_wsel", 32'(wsel), 32'd1);
      chk("t2_rsel", 32'(rsel), 32'b0010);
      step(1'b0, 0, 1'b0, 2'b10);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_busy", 32'(busy), 32'd0);
      idle(1);

      // 3: three batches, wsel walks 0,1,2 and returns to 0
      exp_q = {2'd0, 2'd1, 2'd2, 2'd0};
      s0 = swap_seen; d0 = done_seen;
      step(1'b1, 3, 1'b0, '0);
      for (int b = 0; b < 3; b++) begin
         chk("t3_wsel", 32'(wsel), 32'(exp_q.pop_front()));
         beats(DEPTH);
         step(1'b0, 0, 1'b0, 2'b11);
         idle(1);
      end
      step(1'b0, 0, 1'b0, 2'b11);
      idle(1);
      chk("t3_wsel_end", 32'(wsel), 32'(exp_q.pop_front()));
      chk("t3_swaps", 32'(swap_seen - s0), 32'd3);
      chk("t3_dones", 32'(done_seen - d0), 32'd1);

      // 4: both read ports valid, only one reports -> hold
      step(1'b1, 3, 1'b0, '0);
      beats(DEPTH); idle(2);
      beats(DEPTH); step(1'b0, 0, 1'b0, 2'b10); idle(1);
      beats(DEPTH);
      step(1'b0, 0, 1'b0, 2'b01);
      for (int k = 0; k < 20; k++) begin
         chk("t4_hold", 32'(swap), 32'd0);
         idle(1);
      end
      step(1'b0, 0, 1'b0, 2'b10);
      chk("t4_swap", 32'(swap), 32'd1);
`ifdef GB_SCHED_PERF_EN
      chk("t4_stall_ge21", 32'(stall_cycles >= 32'd21), 32'd1);
`endif
      idle(1);
      step(1'b0, 0, 1'b0, 2'b11);
      idle(1);

      // 5: zero-batch run, then beats ignored outside FILL
      step(1'b1, 0, 1'b0, '0);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      idle(1);
      chk("t5_busy2", 32'(busy), 32'd0);
      step(1'b1, 2, 1'b0, '0);
      beats(DEPTH);
      beats(2);
      beats(DEPTH - 1);
      chk("t5_still_fill", 32'(wr_ready), 32'd1);
      beats(1);
      chk("t5_wait", 32'(wr_ready), 32'd0);
      beats(3);
      step(1'b0, 0, 1'b0, 2'b10);
      idle(1);
      step(1'b0, 0, 1'b0, 2'b11);
      idle(1);

      // 6: reset in the middle of the second batch
      step(1'b1, 2, 1'b0, '0);
      beats(DEPTH); idle(2); beats(2);
      reset_n = 1'b0; start = 1'b0; wr_beat = 1'b0; rd_done = '0;
      #1;
      m_reset();
      chk("t6_wsel", 32'(wsel), 32'd0);
      chk("t6_rsel", 32'(rsel), 32'b1001);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      step(1'b1, 1, 1'b0, '0);
      beats(DEPTH - 1);
      chk("t6_refill", 32'(wr_ready), 32'd1);
      beats(1);
      chk("t6_wait", 32'(wr_ready), 32'd0);
      idle(2);
      step(1'b0, 0, 1'b0, 2'b10);
      idle(1);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [NR-1:0] rdd;
         for (int i = 0; i < NR; i++) rdd[i] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 599) == 0) pulse_reset();
         else step($urandom_range(0, 15) == 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rdd);
      end
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
